// File: rtl/pg_fault_cfg_ctrl.sv
// Mesh-wide power-gated fault configuration sequencer: range-checks set/clear
// commands, quiesces and drains the network, swaps pg_en/pg_node, then settles.
module pg_fault_cfg_ctrl #(
  parameter int MESH_X        = 8,
  parameter int MESH_Y        = 8,
  parameter int DRAIN_TIMEOUT = 256,
  parameter int SETTLE_CYC    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_en,
  input  logic [5:0] cfg_node,
  input  logic       drain_done,
  output logic       quiesce_req,
  output logic       pg_en,
  output logic [5:0] pg_node,
  output logic       cfg_done,
  output logic [1:0] cfg_err,
  output logic       err_pulse
);

  localparam int CNT_MAX = (DRAIN_TIMEOUT > SETTLE_CYC) ? DRAIN_TIMEOUT : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [3:0]       MX          = 4'(MESH_X);
  localparam logic [3:0]       MY          = 4'(MESH_Y);

  localparam logic [1:0] ERR_COORD = 2'b01;
  localparam logic [1:0] ERR_DRAIN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DRAIN,
    UPDATE,
    SETTLE
  } state_e;

  state_e           state_q, state_d;
  logic             sh_en_q, sh_en_d;
  logic [5:0]       sh_node_q, sh_node_d;
  logic             pg_en_q, pg_en_d;
  logic [5:0]       pg_node_q, pg_node_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic bad_coord;
  logic same_cfg;

  // Only a set command carries a meaningful coordinate; clears are never range-checked.
  assign bad_coord = sh_en_q && (({1'b0, sh_node_q[2:0]} >= MX) ||
                                 ({1'b0, sh_node_q[5:3]} >= MY));
  assign same_cfg  = (!sh_en_q && !pg_en_q) ||
                     (sh_en_q && pg_en_q && (sh_node_q == pg_node_q));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    sh_en_d     = sh_en_q;
    sh_node_d   = sh_node_q;
    pg_en_d     = pg_en_q;
    pg_node_d   = pg_node_q;
    cnt_d       = cnt_q;
    cfg_ready   = 1'b0;
    quiesce_req = 1'b0;
    cfg_done    = 1'b0;
    cfg_err     = 2'b00;
    err_pulse   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          sh_en_d   = cfg_en;
          sh_node_d = cfg_node;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (bad_coord) begin
          err_pulse = 1'b1;
          cfg_err   = ERR_COORD;
          state_d   = IDLE;
        end else if (same_cfg) begin
          cfg_done = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        quiesce_req = 1'b1;
        // drain_done is tested first so it wins on the terminal cycle.
        if (drain_done) begin
          state_d = UPDATE;
        end else if (cnt_q == DRAIN_LAST) begin
          err_pulse = 1'b1;
          cfg_err   = ERR_DRAIN;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        quiesce_req = 1'b1;
        pg_en_d     = sh_en_q;
        pg_node_d   = sh_en_q ? sh_node_q : 6'd0;
        cnt_d       = '0;
        state_d     = SETTLE;
      end
      SETTLE: begin
        quiesce_req = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cfg_done = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_en_q   <= 1'b0;
      sh_node_q <= 6'd0;
      pg_en_q   <= 1'b0;
      pg_node_q <= 6'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sh_en_q   <= sh_en_d;
      sh_node_q <= sh_node_d;
      pg_en_q   <= pg_en_d;
      pg_node_q <= pg_node_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pg_en   = pg_en_q;
  assign pg_node = pg_node_q;

endmodule

// File: tb/tb_pg_fault_cfg_ctrl.sv
// Directed bench for pg_fault_cfg_ctrl: cycle-accurate timeline checks of set,
// clear, reject, drain timeout, backpressure/replacement and reset in SETTLE.
module tb_pg_fault_cfg_ctrl;

  localparam int MESH_X        = 6;
  localparam int MESH_Y        = 4;
  localparam int DRAIN_TIMEOUT = 16;
  localparam int SETTLE_CYC    = 4;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_en;
  logic [5:0] cfg_node;
  logic       drain_done;
  logic       quiesce_req;
  logic       pg_en;
  logic [5:0] pg_node;
  logic       cfg_done;
  logic [1:0] cfg_err;
  logic       err_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  pg_fault_cfg_ctrl #(
    .MESH_X       (MESH_X),
    .MESH_Y       (MESH_Y),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .SETTLE_CYC   (SETTLE_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_en     (cfg_en),
    .cfg_node   (cfg_node),
    .drain_done (drain_done),
    .quiesce_req(quiesce_req),
    .pg_en      (pg_en),
    .pg_node    (pg_node),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .err_pulse  (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && cfg_done && err_pulse) check("done_err_exclusive", 32'd1, 32'd0);
  end

  // Full timeline of a real change with drain_done already high; optionally
  // holds a second command on cfg_valid from the cycle after acceptance.
  task automatic real_change(input string tag, input logic en, input logic [5:0] node,
                             input logic old_en, input logic [5:0] old_node,
                             input logic hold, input logic [5:0] hold_node);
    logic [5:0] new_node;
    new_node = en ? node : 6'd0;
    check({tag, "_ready_T"}, cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_en    = en;
    cfg_node  = node;
    tick();                                           // T+1: CHECK
    if (hold) begin
      cfg_en   = 1'b1;
      cfg_node = hold_node;
    end else begin
      cfg_valid = 1'b0;
    end
    check({tag, "_ready_T1"}, cfg_ready, 0);
    check({tag, "_quiesce_T1"}, quiesce_req, 0);
    check({tag, "_err_T1"}, err_pulse, 0);
    check({tag, "_done_T1"}, cfg_done, 0);
    tick();                                           // T+2: DRAIN
    check({tag, "_quiesce_T2"}, quiesce_req, 1);
    check({tag, "_pgen_T2"}, pg_en, old_en);
    tick();                                           // T+3: UPDATE
    check({tag, "_quiesce_T3"}, quiesce_req, 1);
    check({tag, "_pgnode_T3"}, pg_node, old_node);
    tick();                                           // T+4: first SETTLE
    check({tag, "_pgen_T4"}, pg_en, en);
    check({tag, "_pgnode_T4"}, pg_node, new_node);
    check({tag, "_done_T4"}, cfg_done, 0);
    for (int k = 1; k < SETTLE_CYC; k++) begin
      tick();
      check({tag, "_settle_quiesce"}, quiesce_req, 1);
      check({tag, "_settle_ready"}, cfg_ready, 0);
      check({tag, "_settle_done"}, cfg_done, (k == SETTLE_CYC - 1) ? 1 : 0);
    end
    tick();                                           // T+4+SETTLE_CYC: IDLE
    check({tag, "_ready_end"}, cfg_ready, 1);
    check({tag, "_quiesce_end"}, quiesce_req, 0);
    check({tag, "_done_end"}, cfg_done, 0);
    check({tag, "_pgnode_end"}, pg_node, new_node);
  endtask

  task automatic reject(input string tag, input logic [5:0] node, input logic [5:0] cur_node,
                        input logic cur_en);
    cfg_valid = 1'b1;
    cfg_en    = 1'b1;
    cfg_node  = node;
    tick();
    cfg_valid = 1'b0;
    check({tag, "_err"}, err_pulse, 1);
    check({tag, "_code"}, cfg_err, 2'b01);
    check({tag, "_quiesce"}, quiesce_req, 0);
    check({tag, "_done"}, cfg_done, 0);
    tick();
    check({tag, "_ready"}, cfg_ready, 1);
    check({tag, "_err_gone"}, err_pulse, 0);
    check({tag, "_quiesce2"}, quiesce_req, 0);
    check({tag, "_pgen"}, pg_en, cur_en);
    check({tag, "_pgnode"}, pg_node, cur_node);
  endtask

  task automatic redundant(input string tag, input logic en, input logic [5:0] node);
    cfg_valid = 1'b1;
    cfg_en    = en;
    cfg_node  = node;
    tick();
    cfg_valid = 1'b0;
    check({tag, "_done"}, cfg_done, 1);
    check({tag, "_err"}, err_pulse, 0);
    check({tag, "_quiesce"}, quiesce_req, 0);
    tick();
    check({tag, "_ready"}, cfg_ready, 1);
    check({tag, "_done_gone"}, cfg_done, 0);
    check({tag, "_quiesce2"}, quiesce_req, 0);
  endtask

  initial begin
    logic seen;
    logic got_done;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_en     = 1'b0;
    cfg_node   = 6'd0;
    drain_done = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_ready", cfg_ready, 1);
    check("rst_quiesce", quiesce_req, 0);
    check("rst_pgen", pg_en, 0);
    check("rst_pgnode", pg_node, 6'd0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 2'b00);
    check("rst_errp", err_pulse, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", cfg_ready, 1);

    // Out-of-range coordinates: X = MESH_X, Y = MESH_Y
    reject("bad_x", {3'd0, 3'd6}, 6'd0, 1'b0);
    reject("bad_y", {3'd4, 3'd0}, 6'd0, 1'b0);
    // Clear while nothing is active is redundant even with an out-of-range node
    redundant("clear_idle", 1'b0, {3'd7, 3'd7});

    // Drain timeout on a set of (Y=2, X=5)
    drain_done = 1'b0;
    cfg_valid  = 1'b1;
    cfg_en     = 1'b1;
    cfg_node   = {3'd2, 3'd5};
    tick();
    cfg_valid = 1'b0;
    check("to_quiesce_T1", quiesce_req, 0);
    for (int i = 0; i < DRAIN_TIMEOUT; i++) begin
      tick();
      check("to_quiesce", quiesce_req, 1);
      check("to_errp", err_pulse, (i == DRAIN_TIMEOUT - 1) ? 1 : 0);
      if (i == DRAIN_TIMEOUT - 1) check("to_code", cfg_err, 2'b10);
    end
    tick();
    check("to_quiesce_end", quiesce_req, 0);
    check("to_ready_end", cfg_ready, 1);
    check("to_errp_end", err_pulse, 0);
    check("to_pgen", pg_en, 0);
    check("to_pgnode", pg_node, 6'd0);

    // Retry succeeds (X = MESH_X-1 boundary)
    drain_done = 1'b1;
    real_change("set25", 1'b1, {3'd2, 3'd5}, 1'b0, 6'd0, 1'b0, 6'd0);
    check("set25_pgnode_val", pg_node, 6'b010101);

    // Same command again: no quiesce
    redundant("same25", 1'b1, {3'd2, 3'd5});

    // Clear
    real_change("clear", 1'b0, {3'd2, 3'd5}, 1'b1, 6'b010101, 1'b0, 6'd0);
    check("clear_pgen", pg_en, 0);

    // Backpressure: (1,1) held throughout the (2,5) sequence, then replaces it
    real_change("bp_first", 1'b1, {3'd2, 3'd5}, 1'b0, 6'd0, 1'b1, {3'd1, 3'd1});
    real_change("bp_second", 1'b1, {3'd1, 3'd1}, 1'b1, 6'b010101, 1'b0, 6'd0);
    check("bp_pgnode_val", pg_node, 6'b001001);

    // drain_done arriving on the terminal DRAIN cycle wins (Y = MESH_Y-1 boundary)
    drain_done = 1'b0;
    cfg_valid  = 1'b1;
    cfg_en     = 1'b1;
    cfg_node   = {3'd3, 3'd3};
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < DRAIN_TIMEOUT; i++) begin
      tick();
      if (i == DRAIN_TIMEOUT - 1) drain_done = 1'b1;
      #1;
      check("dw_errp", err_pulse, 0);
    end
    tick();
    check("dw_update_quiesce", quiesce_req, 1);
    check("dw_update_pgnode", pg_node, 6'b001001);
    tick();
    check("dw_pgen", pg_en, 1);
    check("dw_pgnode", pg_node, 6'b011011);
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (cfg_done) got_done = 1'b1;
      else tick();
    end
    check("dw_done_within_bound", got_done, 1);
    tick();
    check("dw_ready", cfg_ready, 1);

    // Asynchronous reset in SETTLE
    cfg_valid = 1'b1;
    cfg_en    = 1'b1;
    cfg_node  = {3'd2, 3'd5};
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();                                           // T+5: second SETTLE cycle
    check("rs_in_settle", quiesce_req, 1);
    check("rs_pg_loaded", pg_node, 6'b010101);
    #2 rst_n = 1'b0;
    #1;
    check("rs_pgen", pg_en, 0);
    check("rs_pgnode", pg_node, 6'd0);
    check("rs_quiesce", quiesce_req, 0);
    check("rs_ready", cfg_ready, 1);
    check("rs_done", cfg_done, 0);
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cfg_done || err_pulse || quiesce_req) seen = 1'b1;
    end
    check("rs_no_pulse_after", seen, 0);
    check("rs_pgen_after", pg_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
